atd_rx_ctrl: RTL



---
 rtl/atd_rx_ctrl_pkg.sv | 17 +
 rtl/atd_rx_ctrl_if.sv | 37 +++
 rtl/atd_rx_ctrl_flex_counter.sv | 34 +++
 rtl/atd_rx_ctrl.sv | 122 ++++++++++++
 4 files changed

// File: rtl/atd_rx_ctrl_pkg.sv
// atd_ctrl_pkg: shared types and default constants for the ATD receive
// sequencer.
//   atd_rx_state_t : controller state (IDLE, RECEIVE, HOLD)
//   ATD_NUM_BITS   : default bits per block (shift register width)
//   ATD_TIMEOUT    : default maximum idle gap between bits, in clk cycles
package atd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    HOLD    = 2'd2
  } atd_rx_state_t;

  localparam int ATD_NUM_BITS = 128;
  localparam int ATD_TIMEOUT  = 1024;

endpackage

// File: rtl/atd_rx_ctrl_if.sv
// atd_rx_ctrl_if: control/status bundle between the serial front end plus
// block consumer (master) and the receive sequencer (slave).
//   frame_start, bit_valid, block_ack, abort     : master -> slave
//   ATD_shift_enable, block_ready, bit_count,
//   busy, overrun_err, timeout_err               : slave -> master
interface atd_rx_ctrl_if
  import atd_ctrl_pkg::*;
#(
  parameter int NUM_BITS = ATD_NUM_BITS
);

  localparam int CW = $clog2(NUM_BITS + 1);

  logic          frame_start;
  logic          bit_valid;
  logic          block_ack;
  logic          abort;
  logic          ATD_shift_enable;
  logic          block_ready;
  logic [CW-1:0] bit_count;
  logic          busy;
  logic          overrun_err;
  logic          timeout_err;

  modport master (
    output frame_start, bit_valid, block_ack, abort,
    input  ATD_shift_enable, block_ready, bit_count, busy,
           overrun_err, timeout_err
  );

  modport slave (
    input  frame_start, bit_valid, block_ack, abort,
    output ATD_shift_enable, block_ready, bit_count, busy,
           overrun_err, timeout_err
  );

endinterface

// File: rtl/atd_rx_ctrl_flex_counter.sv
// flex_counter: up-counter with synchronous clear, count enable and a
// programmable terminal value. The count saturates at rollover_val instead
// of wrapping, so rollover_flag stays high until the counter is cleared.
//   clk, n_rst    : clock, async active-low reset
//   clear         : synchronous clear to 0 (wins over count_enable)
//   count_enable  : advance by one per cycle
//   rollover_val  : terminal count
//   rollover_flag : count has reached rollover_val
module flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (count_enable && (count_q != rollover_val)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/atd_rx_ctrl.sv
// atd_rx_ctrl: receive sequencer for the ATD serial-to-parallel shift
// register. Gates the shift enable, counts bits into fixed-length blocks,
// holds the finished block until acknowledged and flags overrun/timeout.
//   clk, n_rst : clock, async active-low reset
//   bus        : atd_rx_ctrl_if slave modport (strobes in, status out)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no block in progress; bits ignored
//   RECEIVE | shifting bits in; idle-gap timer running
//   HOLD    | block complete, ATD_parallel frozen until block_ack
module atd_rx_ctrl
  import atd_ctrl_pkg::*;
#(
  parameter int NUM_BITS       = ATD_NUM_BITS,
  parameter int TIMEOUT_CYCLES = ATD_TIMEOUT
) (
  input logic          clk,
  input logic          n_rst,
  atd_rx_ctrl_if.slave bus
);

  localparam int            CW      = $clog2(NUM_BITS + 1);
  localparam int            TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] FULL    = CW'(NUM_BITS);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  atd_rx_state_t state_q, state_d;
  logic [CW-1:0] bit_count_q, bit_count_d;
  logic          overrun_q, overrun_d;
  logic          timeout_q, timeout_d;
  logic          to_clear;
  logic          to_enable;
  logic          to_expired;

  // Any accepted bit, resync or leaving RECEIVE restarts the gap timer.
  assign to_clear  = (state_q != RECEIVE) || bus.abort || bus.frame_start ||
                     bus.bit_valid;
  assign to_enable = (state_q == RECEIVE);

  flex_counter #(
    .WIDTH (TW)
  ) u_timeout (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (to_clear),
    .count_enable  (to_enable),
    .rollover_val  (TO_LAST),
    .rollover_flag (to_expired)
  );

  always_comb begin
    state_d     = state_q;
    bit_count_d = bit_count_q;
    overrun_d   = overrun_q;
    timeout_d   = timeout_q;
    if (bus.abort) begin
      state_d     = IDLE;
      bit_count_d = '0;
      overrun_d   = 1'b0;
      timeout_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.frame_start) begin
            state_d     = RECEIVE;
            bit_count_d = '0;
          end
        end
        RECEIVE: begin
          if (bus.frame_start) begin
            // A bit arriving with the resync is the new frame's first bit.
            bit_count_d = bus.bit_valid ? CW'(1) : '0;
            if (bus.bit_valid && (FULL == CW'(1))) state_d = HOLD;
          end else if (bus.bit_valid) begin
            bit_count_d = bit_count_q + CW'(1);
            if ((bit_count_q + CW'(1)) == FULL) state_d = HOLD;
          end else if (to_expired) begin
            state_d     = IDLE;
            bit_count_d = '0;
            timeout_d   = 1'b1;
          end
        end
        HOLD: begin
          if (bus.block_ack) begin
            bit_count_d = '0;
            state_d     = bus.frame_start ? RECEIVE : IDLE;
          end else if (bus.bit_valid || bus.frame_start) begin
            overrun_d = 1'b1;
          end
        end
        default: begin
          state_d     = IDLE;
          bit_count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      bit_count_q <= '0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_count_q <= bit_count_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.ATD_shift_enable = bus.bit_valid && (state_q == RECEIVE) &&
                                !bus.abort;
  assign bus.block_ready      = (state_q == HOLD);
  assign bus.busy             = (state_q != IDLE);
  assign bus.bit_count        = bit_count_q;
  assign bus.overrun_err      = overrun_q;
  assign bus.timeout_err      = timeout_q;

endmodule
